contador_modo_param: RTL



---
 rtl/contador_pkg.sv | 15 +
 rtl/contador_modo_param_next.sv | 68 ++++++
 rtl/contador_modo_param.sv | 50 +++++
 3 files changed

// File: rtl/contador_pkg.sv
// Shared constants for the contador counter family: mode select width and encodings.
package contador_pkg;

  localparam int unsigned MODO_W = 3;

  localparam logic [MODO_W-1:0] MODO_UP      = 3'b000;
  localparam logic [MODO_W-1:0] MODO_DN      = 3'b001;
  localparam logic [MODO_W-1:0] MODO_DN_STEP = 3'b010;
  localparam logic [MODO_W-1:0] MODO_LD      = 3'b011;
  localparam logic [MODO_W-1:0] MODO_LD_LIM  = 3'b100;
  localparam logic [MODO_W-1:0] MODO_UP_MOD  = 3'b101;
  localparam logic [MODO_W-1:0] MODO_DN_MOD  = 3'b110;
  localparam logic [MODO_W-1:0] MODO_HOLD    = 3'b111;

endpackage

// File: rtl/contador_modo_param_next.sv
// Combinational next-state for the mode counter: next q, next limit and the wrap flag.
module contador_modo_param_next
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned STEP_DN = 3
) (
  input  logic [WIDTH-1:0]  q,
  input  logic [WIDTH-1:0]  limit,
  input  logic [MODO_W-1:0] modo,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  q_nxt_c,
  output logic [WIDTH-1:0]  lim_nxt_c,
  output logic              rco_nxt_c
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] STEP     = WIDTH'(STEP_DN);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  // Operation decode; rco reflects only the operation selected this cycle.
  always_comb begin
    q_nxt_c   = q;
    lim_nxt_c = limit;
    rco_nxt_c = 1'b0;
    case (modo)
      MODO_UP: begin
        q_nxt_c   = q + ONE;
        rco_nxt_c = (q == ALL_ONES);
      end
      MODO_DN: begin
        q_nxt_c   = q - ONE;
        rco_nxt_c = (q == '0);
      end
      MODO_DN_STEP: begin
        q_nxt_c   = q - STEP;
        rco_nxt_c = (q < STEP);
      end
      MODO_LD: begin
        q_nxt_c = d;
      end
      MODO_LD_LIM: begin
        lim_nxt_c = d;
      end
      MODO_UP_MOD: begin
        // q above limit (e.g. after a load) recovers straight to 0
        if (q >= limit) begin
          q_nxt_c   = '0;
          rco_nxt_c = 1'b1;
        end else begin
          q_nxt_c = q + ONE;
        end
      end
      MODO_DN_MOD: begin
        if (q == '0) begin
          q_nxt_c   = limit;
          rco_nxt_c = 1'b1;
        end else begin
          q_nxt_c = q - ONE;
        end
      end
      default: begin
        q_nxt_c = q;
      end
    endcase
  end

endmodule

// File: rtl/contador_modo_param.sv
// WIDTH-bit up/down/step/load counter with programmable modulo limit and registered wrap pulse.
module contador_modo_param
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned STEP_DN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [MODO_W-1:0] modo,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  q,
  output logic              rco
);

  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q_nxt_c;
  logic [WIDTH-1:0] lim_nxt_c;
  logic             rco_nxt_c;

  contador_modo_param_next #(
    .WIDTH   (WIDTH),
    .STEP_DN (STEP_DN)
  ) u_next (
    .q         (q),
    .limit     (limit),
    .modo      (modo),
    .d         (d),
    .q_nxt_c   (q_nxt_c),
    .lim_nxt_c (lim_nxt_c),
    .rco_nxt_c (rco_nxt_c)
  );

  // State registers; priority rst > enable > mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      rco   <= 1'b0;
      limit <= '1;
    end else if (!enable) begin
      rco <= 1'b0;
    end else begin
      q     <= q_nxt_c;
      limit <= lim_nxt_c;
      rco   <= rco_nxt_c;
    end
  end

endmodule
